// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_if : CTRL/HOST request ports and Memory-side bus         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
);
  logic              ctrl_req;
  logic              ctrl_we;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [WIDTH-1:0]  ctrl_wdata;
  logic              ctrl_gnt;
  logic              ctrl_rvalid;
  logic [WIDTH-1:0]  ctrl_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [WIDTH-1:0]  host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [WIDTH-1:0]  host_rdata;
  logic              host_lock;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [WIDTH-1:0]  mem_data;
  logic [WIDTH-1:0]  mem_q;
  logic [1:0]        owner;

  // Requesters and the Memory model sit on the master side.
  modport master (
    output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    output mem_q,
    input  ctrl_gnt, ctrl_rvalid, ctrl_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_wren, mem_data, owner
  );

  modport slave (
    input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    input  mem_q,
    output ctrl_gnt, ctrl_rvalid, ctrl_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_wren, mem_data, owner
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter : registered req/gnt arbiter sharing the data Memory    |
// | between CTRL and HOST with burst fairness, host lock and read return.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 12,
  parameter int BURST_MAX = 16
) (
  input wire clk,
  input wire rst,
  mem_port_arbiter_if.slave bus
);
  localparam int               CNT_W    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CTRL_OWN = 2'b01,
    HOST_OWN = 2'b10
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic              last_host;
  logic              ctrl_beat;
  logic              host_beat;
  logic              beat;
  logic              at_limit;
  logic [ADDR_W-1:0] addr_hold;
  logic [WIDTH-1:0]  data_hold;
  logic              ctrl_rvalid_q;
  logic              host_rvalid_q;

  assign bus.ctrl_gnt    = (state == CTRL_OWN);
  assign bus.host_gnt    = (state == HOST_OWN);
  assign bus.owner       = state;
  assign ctrl_beat       = bus.ctrl_req && bus.ctrl_gnt;
  assign host_beat       = bus.host_req && bus.host_gnt;
  assign beat            = ctrl_beat || host_beat;
  assign at_limit        = beat && (beat_cnt == CNT_LAST);
  assign bus.mem_wren    = (ctrl_beat && bus.ctrl_we) || (host_beat && bus.host_we);
  assign bus.ctrl_rvalid = ctrl_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.ctrl_rdata  = bus.mem_q;
  assign bus.host_rdata  = bus.mem_q;

  // With no owner the Memory keeps seeing the last driven address/data.
  always_comb begin
    bus.mem_addr = addr_hold;
    bus.mem_data = data_hold;
    if (bus.ctrl_gnt) begin
      bus.mem_addr = bus.ctrl_addr;
      bus.mem_data = bus.ctrl_wdata;
    end else if (bus.host_gnt) begin
      bus.mem_addr = bus.host_addr;
      bus.mem_data = bus.host_wdata;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.host_lock) begin
      state_next = HOST_OWN;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the side that did not own last wins.
          if (bus.host_req && (!bus.ctrl_req || !last_host)) state_next = HOST_OWN;
          else if (bus.ctrl_req)                             state_next = CTRL_OWN;
        end
        CTRL_OWN: begin
          if (!bus.ctrl_req)                   state_next = bus.host_req ? HOST_OWN : IDLE;
          else if (at_limit && bus.host_req)   state_next = HOST_OWN;
        end
        HOST_OWN: begin
          if (!bus.host_req)                   state_next = bus.ctrl_req ? CTRL_OWN : IDLE;
          else if (at_limit && bus.ctrl_req)   state_next = CTRL_OWN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt      <= '0;
      last_host     <= 1'b1;
      addr_hold     <= '0;
      data_hold     <= '0;
      ctrl_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      // Saturating at the limit keeps a locked HOST from wrapping the count.
      if (state_next != state)                 beat_cnt <= '0;
      else if (beat && beat_cnt != CNT_LAST)   beat_cnt <= beat_cnt + 1'b1;
      if (state_next != state && state_next != IDLE) last_host <= (state_next == HOST_OWN);
      addr_hold     <= bus.mem_addr;
      data_hold     <= bus.mem_data;
      ctrl_rvalid_q <= ctrl_beat && !bus.ctrl_we;
      host_rvalid_q <= host_beat && !bus.host_we;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed scenarios plus random traffic vs. model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int WIDTH     = 16;
  localparam int ADDR_W    = 12;
  localparam int BURST_MAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory stub clocked on the falling edge, q valid the cycle after a read.
  logic [WIDTH-1:0] tbmem [4096] = '{default: '0};
  always @(negedge clk) begin
    if (bus.mem_wren) tbmem[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= tbmem[bus.mem_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=CTRL 2=HOST, unbounded beat count.
  logic [WIDTH-1:0]  ref_mem [4096] = '{default: '0};
  int                m_own, m_cnt, m_last;
  bit                m_rv_c, m_rv_h;
  logic [WIDTH-1:0]  m_rd_c, m_rd_h, m_dhold, e_data;
  logic [ADDR_W-1:0] m_ahold, e_addr;
  bit                e_cbeat, e_hbeat;
  logic [WIDTH-1:0]  got_c [$];

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 2;
    m_rv_c = 0; m_rv_h = 0; m_ahold = '0; m_dhold = '0;
  endtask

  task automatic check_cycle();
    #1;
    e_cbeat = bus.ctrl_req && (m_own == 1);
    e_hbeat = bus.host_req && (m_own == 2);
    e_addr  = (m_own == 1) ? bus.ctrl_addr  : (m_own == 2) ? bus.host_addr  : m_ahold;
    e_data  = (m_own == 1) ? bus.ctrl_wdata : (m_own == 2) ? bus.host_wdata : m_dhold;
    check_eq("ctrl_gnt", bus.ctrl_gnt, m_own == 1);
    check_eq("host_gnt", bus.host_gnt, m_own == 2);
    check_eq("owner", bus.owner, m_own[1:0]);
    check_eq("mem_wren", bus.mem_wren, (e_cbeat && bus.ctrl_we) || (e_hbeat && bus.host_we));
    check_eq("mem_addr", bus.mem_addr, e_addr);
    check_eq("mem_data", bus.mem_data, e_data);
    check_eq("ctrl_rvalid", bus.ctrl_rvalid, m_rv_c);
    check_eq("host_rvalid", bus.host_rvalid, m_rv_h);
    if (m_rv_c) check_eq("ctrl_rdata", bus.ctrl_rdata, m_rd_c);
    if (m_rv_h) check_eq("host_rdata", bus.host_rdata, m_rd_h);
    if (bus.ctrl_rvalid) got_c.push_back(bus.ctrl_rdata);
  endtask

  task automatic advance();
    int nxt, my_req, other_req;
    bit beat;
    @(posedge clk);
    #1;
    beat   = e_cbeat || e_hbeat;
    m_rv_c = e_cbeat && !bus.ctrl_we;
    m_rv_h = e_hbeat && !bus.host_we;
    m_rd_c = ref_mem[bus.ctrl_addr];
    m_rd_h = ref_mem[bus.host_addr];
    if (e_cbeat && bus.ctrl_we) ref_mem[bus.ctrl_addr] = bus.ctrl_wdata;
    if (e_hbeat && bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
    m_ahold = e_addr;
    m_dhold = e_data;
    if (bus.host_lock) nxt = 2;
    else if (m_own == 0) begin
      if (bus.ctrl_req && bus.host_req) nxt = 3 - m_last;
      else if (bus.host_req)            nxt = 2;
      else if (bus.ctrl_req)            nxt = 1;
      else                              nxt = 0;
    end else begin
      my_req    = (m_own == 1) ? int'(bus.ctrl_req) : int'(bus.host_req);
      other_req = (m_own == 1) ? int'(bus.host_req) : int'(bus.ctrl_req);
      if (my_req == 0)                                          nxt = (other_req != 0) ? 3 - m_own : 0;
      else if (beat && m_cnt >= BURST_MAX - 1 && other_req != 0) nxt = 3 - m_own;
      else                                                      nxt = m_own;
    end
    if (nxt != m_own) begin
      m_cnt = 0;
      if (nxt != 0) m_last = nxt;
    end else if (beat) m_cnt++;
    m_own = nxt;
  endtask

  task automatic tick();
    check_cycle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_ctrl_gnt", bus.ctrl_gnt, 0);
    check_eq("rst_host_gnt", bus.host_gnt, 0);
    check_eq("rst_mem_wren", bus.mem_wren, 0);
    check_eq("rst_ctrl_rvalid", bus.ctrl_rvalid, 0);
    check_eq("rst_host_rvalid", bus.host_rvalid, 0);
    check_eq("rst_owner", bus.owner, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_mem_data", bus.mem_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_ctrl(input bit req, input bit we, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    bus.ctrl_req = req; bus.ctrl_we = we; bus.ctrl_addr = a; bus.ctrl_wdata = d;
  endtask

  task automatic set_host(input bit req, input bit we, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
  endtask

  // Hold a request until the model says the beat was taken (bounded).
  task automatic do_beat(input int who, input bit we, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    int n;
    bit done;
    n = 0; done = 0;
    if (who == 1) set_ctrl(1, we, a, d);
    else          set_host(1, we, a, d);
    while (!done) begin
      check_cycle();
      done = (who == 1) ? e_cbeat : e_hbeat;
      advance();
      n++;
      if (!done && n >= 64) begin
        check_eq("beat_timeout", done, 1);
        done = 1;
      end
    end
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 31));
  endfunction

  initial begin
    int nb, cyc;
    #200000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, cyc;
    set_ctrl(0, 0, '0, '0);
    set_host(0, 0, '0, '0);
    bus.host_lock = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // CTRL alone: write then read back 0x100..0x103.
    for (int i = 0; i < 4; i++) do_beat(1, 1, 12'h100 + 12'(i), 16'(5 + i));
    got_c.delete();
    for (int i = 0; i < 4; i++) do_beat(1, 0, 12'h100 + 12'(i), '0);
    set_ctrl(0, 0, '0, '0);
    tick();
    tick();
    check_eq("t2_nread", got_c.size(), 4);
    for (int i = 0; i < got_c.size() && i < 4; i++) check_eq("t2_rdata", got_c[i], 5 + i);

    // Tie from IDLE right after reset: CTRL first, then HOST with no gap.
    do_reset();
    set_ctrl(1, 0, 12'h010, '0);
    set_host(1, 0, 12'h011, '0);
    tick();
    check_eq("t3_tie_owner", bus.owner, 1);
    tick();
    set_ctrl(0, 0, '0, '0);
    tick();
    check_eq("t3_handover", bus.owner, 2);
    set_host(0, 0, '0, '0);
    tick();
    tick();

    // Fairness: HOST arrives at CTRL beat 3, CTRL keeps exactly BURST_MAX beats.
    do_reset();
    set_ctrl(1, 0, 12'h000, '0);
    nb = 0; cyc = 0;
    while (!bus.host_gnt && cyc < 80) begin
      if (nb == 3) set_host(1, 1, 12'h020, 16'h0055);
      check_cycle();
      if (bus.ctrl_gnt && bus.ctrl_req) nb++;
      advance();
      cyc++;
    end
    check_eq("t4_ctrl_burst", nb, BURST_MAX);
    check_eq("t4_host_owns", bus.host_gnt, 1);
    repeat (3) tick();
    set_host(0, 0, '0, '0);
    repeat (2) tick();
    set_ctrl(0, 0, '0, '0);
    tick();

    // host_lock during a CTRL read burst.
    do_reset();
    set_ctrl(1, 0, 12'h101, '0);
    repeat (3) tick();
    bus.host_lock = 1'b1;
    tick();
    check_eq("t5_lock_owner", bus.owner, 2);
    check_eq("t5_last_rvalid", bus.ctrl_rvalid, 1);
    repeat (5) tick();
    bus.host_lock = 1'b0;
    repeat (3) tick();
    set_ctrl(0, 0, '0, '0);
    tick();

    // Write/read hazard at the top address.
    do_beat(2, 1, 12'hFFF, 16'hFFFF);
    set_host(0, 0, '0, '0);
    got_c.delete();
    do_beat(1, 0, 12'hFFF, '0);
    set_ctrl(0, 0, '0, '0);
    tick();
    check_eq("t6_nread", got_c.size(), 1);
    if (got_c.size() > 0) check_eq("t6_rdata", got_c[0], 16'hFFFF);

    // Reset mid-burst drops the read in flight.
    set_ctrl(1, 0, 12'h102, '0);
    repeat (3) tick();
    do_reset();
    repeat (2) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!(bus.ctrl_req && m_own != 1)) begin
        bus.ctrl_req   = bus.ctrl_req ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
        bus.ctrl_we    = 1'($urandom_range(0, 1));
        bus.ctrl_addr  = rand_addr();
        bus.ctrl_wdata = 16'($urandom);
      end
      if (!(bus.host_req && m_own != 2)) begin
        bus.host_req   = bus.host_req ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
        bus.host_we    = 1'($urandom_range(0, 1));
        bus.host_addr  = rand_addr();
        bus.host_wdata = 16'($urandom);
      end
      bus.host_lock = bus.host_lock ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 199) == 0);
      tick();
      if (i % 1000 == 999) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
